// File: rtl/srl_cascade_chain_pkg.sv
`default_nettype none
// ============================================================================
// Module   : srl_cascade_pkg
// Purpose  : Shared constants, width helpers and types for the SRL cascade
//            chain (default geometry, address/counter widths, stage source).
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package srl_cascade_pkg;

   localparam int unsigned C_DEF_NLUT  = 4;
   localparam int unsigned C_DEF_DEPTH = 32;

   // Per-stage DI1 source selection.
   typedef enum logic {
      SRC_EXT     = 1'b0,
      SRC_CASCADE = 1'b1
   } stage_src_e;

   // Cascade-mode vector for the default geometry (bit i = stage i).
   typedef logic [C_DEF_NLUT-1:0] cascade_mode_t;

   function automatic int unsigned addr_w(input int unsigned depth);
      return $clog2(depth);
   endfunction

   // Counter must represent 0..nlut*depth inclusive.
   function automatic int unsigned cnt_w(input int unsigned nlut, input int unsigned depth);
      return $clog2(nlut * depth + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/srl_cascade_chain_if.sv
`default_nettype none
// ============================================================================
// Module   : srl_cascade_chain_if
// Purpose  : Bundle of control/data signals of the SRL cascade chain.
// Signals  : ce          shift enable for all stages
//            di          per-stage external serial data
//            cascade_sel per-stage cascade select (head bit ignored)
//            addr        per-stage read address, ADDR_W bits each
//            q           per-stage addressed read data
//            mc31        per-stage last bit
//            fill_cnt    saturating shift counter since reset
//            full        fill_cnt at NLUT*DEPTH
// Modports : master drives ce/di/cascade_sel/addr; slave (the chain) drives
//            q/mc31/fill_cnt/full.
// Revision : 1.0 - initial release
// ============================================================================
interface srl_cascade_chain_if
   import srl_cascade_pkg::*;
#(
   parameter int NLUT  = C_DEF_NLUT,
   parameter int DEPTH = C_DEF_DEPTH
);
   localparam int ADDR_W = addr_w(DEPTH);
   localparam int CNT_W  = cnt_w(NLUT, DEPTH);

   logic                     ce;
   logic [NLUT-1:0]          di;
   logic [NLUT-1:0]          cascade_sel;
   logic [NLUT*ADDR_W-1:0]   addr;
   logic [NLUT-1:0]          q;
   logic [NLUT-1:0]          mc31;
   logic [CNT_W-1:0]         fill_cnt;
   logic                     full;

   modport master (
      output ce, di, cascade_sel, addr,
      input  q, mc31, fill_cnt, full
   );

   modport slave (
      input  ce, di, cascade_sel, addr,
      output q, mc31, fill_cnt, full
   );

endinterface
`default_nettype wire

// File: rtl/srl_cascade_chain_stage.sv
`default_nettype none
// ============================================================================
// Module   : srl_stage
// Purpose  : One DEPTH-bit addressable shift register (SRLC32E-style LUT).
// Ports    : clk  clock
//            rst  synchronous active-high reset, reloads INIT
//            ce   shift enable
//            d    serial input (enters bit 0)
//            addr read address
//            q    sr[addr], combinational
//            mc31 sr[DEPTH-1], combinational
// Revision : 1.0 - initial release
// ============================================================================
module srl_stage
   import srl_cascade_pkg::*;
#(
   parameter int               DEPTH = C_DEF_DEPTH,
   parameter logic [DEPTH-1:0] INIT  = '0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      ce,
   input  logic                      d,
   input  logic [addr_w(DEPTH)-1:0]  addr,
   output logic                      q,
   output logic                      mc31
);

   logic [DEPTH-1:0] r_sr;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sr <= INIT;
      end else if (ce) begin
         r_sr <= {r_sr[DEPTH-2:0], d};
      end
   end

   // DEPTH is a power of two, so every addr value is a valid index.
   assign q    = r_sr[addr];
   assign mc31 = r_sr[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/srl_cascade_chain.sv
`default_nettype none
// ============================================================================
// Module   : srl_cascade_chain
// Purpose  : NLUT cascadable addressable shift registers with per-stage DI1
//            mux (external di or mc31 of the stage above), INIT reload on
//            reset, saturating fill counter and optional registered q.
// Ports    : clk  clock, all state updates on rising edge
//            rst  synchronous active-high reset (priority over ce)
//            bus  srl_cascade_chain_if.slave: ce, di, cascade_sel, addr in;
//                 q, mc31, fill_cnt, full out
// Macro    : SRL_CASCADE_QREG_EN - when defined q is registered (one cycle
//            read latency, sampled from pre-shift contents every cycle,
//            cleared by rst). Undefined: q is combinational.
// Revision : 1.0 - initial release
// ============================================================================
module srl_cascade_chain
   import srl_cascade_pkg::*;
#(
   parameter int                    NLUT  = C_DEF_NLUT,
   parameter int                    DEPTH = C_DEF_DEPTH,
   parameter logic [NLUT*DEPTH-1:0] INIT  = '0
) (
   input  logic                     clk,
   input  logic                     rst,
   srl_cascade_chain_if.slave       bus
);

   localparam int               ADDR_W     = addr_w(DEPTH);
   localparam int               CNT_W      = cnt_w(NLUT, DEPTH);
   localparam logic [CNT_W-1:0] C_FILL_MAX = CNT_W'(NLUT * DEPTH);

   logic [NLUT-1:0]  w_d;
   logic [NLUT-1:0]  w_mc31;
   logic [NLUT-1:0]  w_q_rd;
   logic [CNT_W-1:0] r_fill_cnt;

   // The head stage has nothing above it, so its cascade select is unused.
   logic w_unused_head_sel;
   assign w_unused_head_sel = bus.cascade_sel[NLUT-1];

   generate
      for (genvar i = 0; i < NLUT; i++) begin : g_stage
         if (i == NLUT - 1) begin : g_head
            assign w_d[i] = bus.di[i];
         end else begin : g_body
            stage_src_e w_src;
            assign w_src  = stage_src_e'(bus.cascade_sel[i]);
            // mc31 of the stage above is its registered tail bit, so the
            // cascade advances one bit per stage per edge with no ripple.
            assign w_d[i] = (w_src == SRC_CASCADE) ? w_mc31[i+1] : bus.di[i];
         end

         srl_stage #(
            .DEPTH (DEPTH),
            .INIT  (INIT[i*DEPTH +: DEPTH])
         ) u_stage (
            .clk   (clk),
            .rst   (rst),
            .ce    (bus.ce),
            .d     (w_d[i]),
            .addr  (bus.addr[i*ADDR_W +: ADDR_W]),
            .q     (w_q_rd[i]),
            .mc31  (w_mc31[i])
         );
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         r_fill_cnt <= '0;
      end else if (bus.ce && (r_fill_cnt != C_FILL_MAX)) begin
         r_fill_cnt <= r_fill_cnt + 1'b1;
      end
   end

`ifdef SRL_CASCADE_QREG_EN
   // Samples the pre-shift contents on every edge, independent of ce.
   logic [NLUT-1:0] r_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_q <= '0;
      end else begin
         r_q <= w_q_rd;
      end
   end

   assign bus.q = r_q;
`else
   assign bus.q = w_q_rd;
`endif

   assign bus.mc31     = w_mc31;
   assign bus.fill_cnt = r_fill_cnt;
   assign bus.full     = (r_fill_cnt == C_FILL_MAX);

endmodule
`default_nettype wire

// File: tb/tb_srl_cascade_chain.sv
`default_nettype none
// ============================================================================
// Module   : tb_srl_cascade_chain
// Purpose  : Self-checking bench for srl_cascade_chain. A behavioural model
//            produces expected q/mc31/fill_cnt/full per edge into a queue
//            that is popped after each edge; directed scenario checks sit
//            in per-scenario tasks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_srl_cascade_chain;
   import srl_cascade_pkg::*;

   localparam int NLUT   = 4;
   localparam int DEPTH  = 32;
   localparam int ADDR_W = addr_w(DEPTH);
   localparam int CNT_W  = cnt_w(NLUT, DEPTH);
   localparam int FMAX   = NLUT * DEPTH;
   localparam logic [NLUT*DEPTH-1:0] INIT = {32'h0, 32'h0, 32'h0, 32'h8000_0001};

   typedef struct {
      logic [NLUT-1:0]  q;
      logic [NLUT-1:0]  mc31;
      logic [CNT_W-1:0] fill;
      logic             full;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   srl_cascade_chain_if #(.NLUT(NLUT), .DEPTH(DEPTH)) bus ();

   srl_cascade_chain #(.NLUT(NLUT), .DEPTH(DEPTH), .INIT(INIT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   exp_t                   sb[$];
   logic [DEPTH-1:0]       m_sr [NLUT];
   int                     m_fill = 0;
   logic [NLUT*ADDR_W-1:0] cur_addr = '0;
   int                     checks = 0;
   int                     errors = 0;

   function automatic logic [NLUT-1:0] model_q();
      logic [NLUT-1:0] r;
      for (int i = 0; i < NLUT; i++) r[i] = m_sr[i][cur_addr[i*ADDR_W +: ADDR_W]];
      return r;
   endfunction

   function automatic logic [NLUT-1:0] model_mc31();
      logic [NLUT-1:0] r;
      for (int i = 0; i < NLUT; i++) r[i] = m_sr[i][DEPTH-1];
      return r;
   endfunction

   function automatic void set_addr(input int stage, input int a);
      cur_addr[stage*ADDR_W +: ADDR_W] = ADDR_W'(a);
   endfunction

   // One clock: drive at negedge, update model, push expectation, pop and
   // compare 1 time unit after the rising edge.
   task automatic step(input logic r, input logic c, input logic [NLUT-1:0] d,
                       input logic [NLUT-1:0] sel);
      exp_t             e;
      logic [NLUT-1:0]  q_pre;
      logic [DEPTH-1:0] nxt [NLUT];
      @(negedge clk);
      rst = r; bus.ce = c; bus.di = d; bus.cascade_sel = sel; bus.addr = cur_addr;
      q_pre = model_q();
      if (r) begin
         for (int i = 0; i < NLUT; i++) m_sr[i] = INIT[i*DEPTH +: DEPTH];
         m_fill = 0;
      end else if (c) begin
         for (int i = 0; i < NLUT; i++)
            nxt[i] = {m_sr[i][DEPTH-2:0],
                      ((i < NLUT-1) && sel[i]) ? m_sr[(i+1)%NLUT][DEPTH-1] : d[i]};
         for (int i = 0; i < NLUT; i++) m_sr[i] = nxt[i];
         if (m_fill < FMAX) m_fill++;
      end
`ifdef SRL_CASCADE_QREG_EN
      e.q = r ? '0 : q_pre;
`else
      e.q = model_q();
`endif
      e.mc31 = model_mc31();
      e.fill = CNT_W'(m_fill);
      e.full = (m_fill == FMAX);
      sb.push_back(e);
      @(posedge clk);
      #1;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL sb_empty got 0 entries expected 1");
      end else begin
         e = sb.pop_front();
         if (bus.q !== e.q || bus.mc31 !== e.mc31 || bus.fill_cnt !== e.fill
             || bus.full !== e.full) begin
            errors++;
            $display("FAIL sb_cycle t=%0t got q=%b mc31=%b fill=%0d full=%b expected q=%b mc31=%b fill=%0d full=%b",
                     $time, bus.q, bus.mc31, bus.fill_cnt, bus.full,
                     e.q, e.mc31, e.fill, e.full);
         end
      end
   endtask

   task automatic test_reset();
      cur_addr = '0;
      step(1'b1, 1'b1, '1, '0);
      checks++;
      if (bus.mc31 !== 4'b0001 || bus.fill_cnt !== '0 || bus.full !== 1'b0) begin
         errors++;
         $display("FAIL reset_state got mc31=%b fill=%0d full=%b expected mc31=0001 fill=0 full=0",
                  bus.mc31, bus.fill_cnt, bus.full);
      end
      step(1'b0, 1'b0, '0, '0);
      checks++;
      if (bus.q[0] !== 1'b1) begin
         errors++;
         $display("FAIL reset_q0 got %b expected 1", bus.q[0]);
      end
   endtask

   task automatic test_independent();
`ifdef SRL_CASCADE_QREG_EN
      localparam int HI_EDGE = 7;
`else
      localparam int HI_EDGE = 6;
`endif
      cur_addr = '0;
      step(1'b1, 1'b0, '0, '0);
      set_addr(2, 5);
      for (int k = 1; k <= 7; k++) begin
         step(1'b0, 1'b1, (k == 1) ? 4'b0100 : 4'b0000, 4'b0000);
         checks++;
         if (bus.q[2] !== (k == HI_EDGE)) begin
            errors++;
            $display("FAIL indep_q2 edge=%0d got %b expected %b", k, bus.q[2], (k == HI_EDGE));
         end
         if (k == 6) begin
            checks++;
            if (bus.fill_cnt !== CNT_W'(6)) begin
               errors++;
               $display("FAIL indep_fill got %0d expected 6", bus.fill_cnt);
            end
         end
      end
   endtask

   task automatic test_full_cascade();
      logic [NLUT-1:0] d;
      cur_addr = '0;
      step(1'b1, 1'b0, '0, '0);
      for (int k = 1; k <= 136; k++) begin
         d = {(k == 1), 3'($urandom)};
         step(1'b0, 1'b1, d, {1'($urandom), 3'b111});
         checks++;
         if (bus.mc31[3] !== (k == 32)) begin
            errors++;
            $display("FAIL casc_mc31_3 edge=%0d got %b expected %b", k, bus.mc31[3], (k == 32));
         end
         if (k == 31 || k == 127 || k == 128) begin
            checks++;
            if (bus.mc31[0] !== (k != 127)) begin
               errors++;
               $display("FAIL casc_mc31_0 edge=%0d got %b expected %b", k, bus.mc31[0], (k != 127));
            end
         end
         checks++;
         if (bus.full !== (k >= 128)) begin
            errors++;
            $display("FAIL casc_full edge=%0d got %b expected %b", k, bus.full, (k >= 128));
         end
         if (k >= 128) begin
            checks++;
            if (bus.fill_cnt !== CNT_W'(128)) begin
               errors++;
               $display("FAIL casc_sat edge=%0d got %0d expected 128", k, bus.fill_cnt);
            end
         end
      end
   endtask

   task automatic test_toggle_and_reset();
      cur_addr = '0;
      step(1'b1, 1'b0, '0, '0);
      for (int k = 0; k < 40; k++)
         step(1'b0, 1'b1, {1'($urandom), 1'b1, 2'($urandom)}, 4'b0000);
      // Hold with the stage-1 cascade select flipped, sweeping its address.
      set_addr(1, 0);  step(1'b0, 1'b0, 4'b1111, 4'b0010);
      set_addr(1, 7);  step(1'b0, 1'b0, 4'b0000, 4'b0010);
      set_addr(1, 31); step(1'b0, 1'b0, 4'b1111, 4'b0010);
      checks++;
      if (bus.fill_cnt !== CNT_W'(40)) begin
         errors++;
         $display("FAIL hold_fill got %0d expected 40", bus.fill_cnt);
      end
      // Stage 2 is all ones by now; di[1]=0 must be ignored.
      set_addr(1, 0);
      step(1'b0, 1'b1, 4'b0000, 4'b0010);
      step(1'b0, 1'b0, 4'b0000, 4'b0010);
      checks++;
      if (bus.q[1] !== 1'b1) begin
         errors++;
         $display("FAIL toggle_q1 got %b expected 1", bus.q[1]);
      end
      // Reset wins over ce: INIT reloaded with no shift on top.
      step(1'b1, 1'b1, 4'b1111, 4'b0000);
      checks++;
      if (bus.mc31 !== 4'b0001 || bus.fill_cnt !== '0 || bus.full !== 1'b0) begin
         errors++;
         $display("FAIL rst_ce got mc31=%b fill=%0d full=%b expected mc31=0001 fill=0 full=0",
                  bus.mc31, bus.fill_cnt, bus.full);
      end
      step(1'b0, 1'b0, '0, '0);
      checks++;
      if (bus.q !== 4'b0001) begin
         errors++;
         $display("FAIL rst_ce_q got %b expected 0001", bus.q);
      end
   endtask

   task automatic test_addr_change();
      cur_addr = '0;
      step(1'b1, 1'b0, '0, '0);
      step(1'b0, 1'b0, '0, '0);
      @(negedge clk);
      set_addr(0, 3);
      bus.addr = cur_addr;
      #1;
      checks++;
`ifdef SRL_CASCADE_QREG_EN
      if (bus.q[0] !== 1'b1) begin
         errors++;
         $display("FAIL addr_same_cycle got %b expected 1", bus.q[0]);
      end
`else
      if (bus.q[0] !== 1'b0) begin
         errors++;
         $display("FAIL addr_same_cycle got %b expected 0", bus.q[0]);
      end
`endif
      step(1'b0, 1'b0, '0, '0);
      checks++;
      if (bus.q[0] !== 1'b0) begin
         errors++;
         $display("FAIL addr_next_cycle got %b expected 0", bus.q[0]);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.ce = 1'b0; bus.di = '0; bus.cascade_sel = '0; bus.addr = '0;
      test_reset();
      test_independent();
      test_full_cascade();
      test_toggle_and_reset();
      test_addr_change();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
